// File: rtl/rhd_spi_pkg.sv
// rtl/rhd_spi_pkg.sv - shared constants and types for the RHD2000 SPI command and result paths
package rhd_spi_pkg;

  localparam int WORD_BITS         = 16;
  localparam int N_CMD             = 35;
  localparam int PIPE_DELAY        = 2;
  localparam int FIRST_AUX_SLOT    = 32;
  localparam int LAST_CONVERT_SLOT = 31;
  localparam int CH_W              = 6;

  localparam logic [7:0] REG3_WRITE_HDR = 8'h83;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } rx_state_e;

endpackage

// File: rtl/miso_shift_word.sv
// rtl/miso_shift_word.sv - MSB-first MISO deserialiser with bit counter
module miso_shift_word #(
  parameter int WORD_BITS = 16,
  parameter int CNT_W     = $clog2(WORD_BITS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 active,
  input  logic                 word_start,
  input  logic                 sample_en,
  input  logic                 miso,
  output logic [WORD_BITS-1:0] word,
  output logic [CNT_W-1:0]     bit_cnt,
  output logic                 word_done
);

  logic                 take;
  logic [CNT_W-1:0]     cnt_base;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_BITS-1:0] shreg_q, shreg_d;

  // A sample coinciding with word_start is the first bit of the new word.
  always_comb begin
    take      = sample_en && (active || word_start);
    cnt_base  = word_start ? '0 : cnt_q;
    cnt_d     = cnt_base;
    shreg_d   = shreg_q;
    if (take) begin
      cnt_d   = cnt_base + CNT_W'(1);
      shreg_d = {shreg_q[WORD_BITS-2:0], miso};
    end
    word_done = take && (cnt_base == CNT_W'(WORD_BITS - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  assign word    = shreg_q;
  assign bit_cnt = cnt_q;

endmodule

// File: rtl/miso_result_decoder.sv
// rtl/miso_result_decoder.sv - deserialises MISO words and tags them with the slot issued PIPE_DELAY words earlier
module miso_result_decoder #(
  parameter int WORD_BITS  = rhd_spi_pkg::WORD_BITS,
  parameter int N_CMD      = rhd_spi_pkg::N_CMD,
  parameter int PIPE_DELAY = rhd_spi_pkg::PIPE_DELAY
) (
  input  logic                 dataclk,
  input  logic                 reset,
  input  logic                 word_start,
  input  logic [5:0]           channel,
  input  logic                 miso_sample_en,
  input  logic                 MISO,
  output logic [WORD_BITS-1:0] result_word,
  output logic [5:0]           result_channel,
  output logic                 result_valid,
  output logic                 result_is_aux,
  output logic                 frame_end,
  output logic                 framing_error
);
  import rhd_spi_pkg::*;

  localparam int               HIST_N    = PIPE_DELAY + 1;
  localparam int               FILL_W    = $clog2(HIST_N + 1);
  localparam int               CNT_W     = $clog2(WORD_BITS + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(HIST_N);
  localparam logic [5:0]       LAST_SLOT = 6'(N_CMD - 1);
  localparam logic [5:0]       AUX_LO    = 6'(FIRST_AUX_SLOT);

  rx_state_e            state_q, state_d;
  logic [5:0]           hist_q [HIST_N];
  logic [FILL_W-1:0]    fill_q;
  logic [WORD_BITS-1:0] shift_word;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 word_done;
  logic                 truncated;
  logic [5:0]           tag;
  logic                 tag_ok;

  logic [WORD_BITS-1:0] result_word_q;
  logic [5:0]           result_channel_q;
  logic                 result_valid_q, result_is_aux_q, frame_end_q, framing_error_q;

  miso_shift_word #(.WORD_BITS(WORD_BITS)) u_shift (
    .clk        (dataclk),
    .reset      (reset),
    .active     (state_q == ST_SHIFT),
    .word_start (word_start),
    .sample_en  (miso_sample_en),
    .miso       (MISO),
    .word       (shift_word),
    .bit_cnt    (bit_cnt),
    .word_done  (word_done)
  );

  assign truncated = word_start && (state_q == ST_SHIFT) && (bit_cnt != '0);
  assign tag       = hist_q[PIPE_DELAY];
  assign tag_ok    = (fill_q == FILL_FULL) && (tag <= LAST_SLOT);

  always_comb begin
    state_d = state_q;
    if (word_done) begin
      state_d = ST_DONE;
    end else if (word_start) begin
      state_d = ST_SHIFT;
    end else begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_SHIFT: state_d = ST_SHIFT;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge dataclk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      fill_q           <= '0;
      for (int i = 0; i < HIST_N; i++) hist_q[i] <= '0;
      result_word_q    <= '0;
      result_channel_q <= '0;
      result_valid_q   <= 1'b0;
      result_is_aux_q  <= 1'b0;
      frame_end_q      <= 1'b0;
      framing_error_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      framing_error_q <= framing_error_q | truncated;
      // History advances on every word_start, truncated words included.
      if (word_start) begin
        hist_q[0] <= channel;
        for (int i = 1; i < HIST_N; i++) hist_q[i] <= hist_q[i-1];
        if (fill_q != FILL_FULL) fill_q <= fill_q + FILL_W'(1);
      end
      result_valid_q  <= 1'b0;
      result_is_aux_q <= 1'b0;
      frame_end_q     <= 1'b0;
      if (state_q == ST_DONE) begin
        result_word_q    <= shift_word;
        result_channel_q <= tag;
        result_valid_q   <= tag_ok;
        result_is_aux_q  <= tag_ok && (tag >= AUX_LO);
        frame_end_q      <= tag_ok && (tag == LAST_SLOT);
      end
    end
  end

  assign result_word    = result_word_q;
  assign result_channel = result_channel_q;
  assign result_valid   = result_valid_q;
  assign result_is_aux  = result_is_aux_q;
  assign frame_end      = frame_end_q;
  assign framing_error  = framing_error_q;

endmodule

// File: tb/tb_miso_result_decoder.sv
// tb/tb_miso_result_decoder.sv - scoreboard bench for miso_result_decoder
module tb_miso_result_decoder;
  import rhd_spi_pkg::*;

  logic        dataclk;
  logic        reset;
  logic        word_start;
  logic [5:0]  channel;
  logic        miso_sample_en;
  logic        MISO;
  logic [15:0] result_word;
  logic [5:0]  result_channel;
  logic        result_valid;
  logic        result_is_aux;
  logic        frame_end;
  logic        framing_error;

  miso_result_decoder dut (
    .dataclk        (dataclk),
    .reset          (reset),
    .word_start     (word_start),
    .channel        (channel),
    .miso_sample_en (miso_sample_en),
    .MISO           (MISO),
    .result_word    (result_word),
    .result_channel (result_channel),
    .result_valid   (result_valid),
    .result_is_aux  (result_is_aux),
    .frame_end      (frame_end),
    .framing_error  (framing_error)
  );

  initial dataclk = 1'b0;
  always #5 dataclk = ~dataclk;

  int cyc = 0;
  always @(posedge dataclk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] w;
    logic [5:0]  ch;
    bit          aux;
    bit          fe;
    int          at;
  } exp_t;

  exp_t exp_q[$];
  int   hist_m[$];
  int   total   = 0;
  int   bad     = 0;
  int   fe_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge dataclk) begin
    exp_t e;
    if (frame_end === 1'b1) fe_seen++;
    if (result_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {26'd0, result_channel}, 32'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("result_word", {16'd0, result_word}, {16'd0, e.w});
        check("result_channel", {26'd0, result_channel}, {26'd0, e.ch});
        check("result_is_aux", {31'd0, result_is_aux}, {31'd0, e.aux});
        check("frame_end", {31'd0, frame_end}, {31'd0, e.fe});
        check("latency", 32'(cyc), 32'(e.at));
      end
    end else if (result_valid === 1'b0) begin
      check("strobe_qual", {30'd0, frame_end, result_is_aux}, 32'd0);
    end
  end

  // Drives one word; nbits < 16 leaves it truncated. The expected tag is the
  // slot issued PIPE_DELAY words earlier, if that slot is a real command.
  task automatic send_word(input logic [5:0] ch, input logic [15:0] d, input int nbits, input bit same);
    int   k;
    int   b;
    exp_t e;
    k = hist_m.size();
    hist_m.push_back(int'(ch));
    @(posedge dataclk); #1;
    word_start     = 1'b1;
    channel        = ch;
    miso_sample_en = same;
    MISO           = same ? d[15] : 1'b0;
    b              = same ? 1 : 0;
    for (int i = b; i < nbits; i++) begin
      @(posedge dataclk); #1;
      word_start     = 1'b0;
      miso_sample_en = 1'b1;
      MISO           = d[15-i];
      if (i == 15 && k >= PIPE_DELAY && hist_m[k-PIPE_DELAY] < N_CMD) begin
        e.w   = d;
        e.ch  = 6'(hist_m[k-PIPE_DELAY]);
        e.aux = (hist_m[k-PIPE_DELAY] >= 32);
        e.fe  = (hist_m[k-PIPE_DELAY] == 34);
        e.at  = cyc + 2;
        exp_q.push_back(e);
      end
      @(posedge dataclk); #1;
      miso_sample_en = 1'b0;
    end
    @(posedge dataclk); #1;
    word_start     = 1'b0;
    miso_sample_en = 1'b0;
    repeat (3) @(posedge dataclk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_word"}, {16'd0, result_word}, 32'd0);
    check({tag, "_channel"}, {26'd0, result_channel}, 32'd0);
    check({tag, "_valid"}, {31'd0, result_valid}, 32'd0);
    check({tag, "_aux"}, {31'd0, result_is_aux}, 32'd0);
    check({tag, "_frame_end"}, {31'd0, frame_end}, 32'd0);
    check({tag, "_framing_error"}, {31'd0, framing_error}, 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    word_start     = 1'b0;
    channel        = '0;
    miso_sample_en = 1'b0;
    MISO           = 1'b0;
    repeat (3) @(posedge dataclk);
    #1 reset = 1'b0;
    @(negedge dataclk);
    check_outputs_zero("reset");

    for (int f = 0; f < 2; f++)
      for (int s = 0; s < 35; s++)
        send_word(6'(s), 16'hA500 | 16'(s), 16, 1'b0);

    send_word(6'd0, 16'h8001, 16, 1'b1);
    send_word(6'd1, 16'h4003, 16, 1'b1);
    check("no_err_before_trunc", {31'd0, framing_error}, 32'd0);

    send_word(6'd2, 16'h1234, 7, 1'b0);
    send_word(6'd3, 16'h5A5A, 16, 1'b0);
    @(negedge dataclk);
    check("framing_error_set", {31'd0, framing_error}, 32'd1);

    send_word(6'd4, 16'h0F0F, 16, 1'b0);
    send_word(6'd40, 16'hDEAD, 16, 1'b0);
    send_word(6'd5, 16'hBEEF, 16, 1'b0);
    send_word(6'd6, 16'h0001, 16, 1'b0);
    send_word(6'd7, 16'hFFFE, 16, 1'b0);
    @(negedge dataclk);
    check("framing_error_sticky", {31'd0, framing_error}, 32'd1);

    send_word(6'd8, 16'hFFFF, 9, 1'b0);
    @(posedge dataclk); #1 reset = 1'b1;
    repeat (2) @(posedge dataclk);
    #1 reset = 1'b0;
    hist_m.delete();
    @(negedge dataclk);
    check_outputs_zero("midword_reset");

    for (int s = 0; s < 4; s++)
      send_word(6'(s), 16'h1100 | 16'(s), 16, 1'b0);

    repeat (5) @(posedge dataclk);
    @(negedge dataclk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("frame_end_count", 32'(fe_seen), 32'd2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
